// File: rtl/pll_reset_sequencer.sv
// Releases system and PSRAM resets once PLL lock has been stable, re-asserting them on lock loss.
// Build option PLL_RESEQ_RETRY_EN adds a lock timeout that pulses the PLL RESET input.
module pll_reset_sequencer #(
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned PSRAM_DELAY  = 20250,
    parameter int unsigned LOCK_TIMEOUT = 1048576,
    parameter int unsigned PLL_RST_CYC  = 16,
    parameter int unsigned CNT_W        = 21
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_lock,
    input  logic       i_lock_lost_clr,
    output logic       o_sys_rst_n,
    output logic       o_psram_rst_n,
    output logic       o_pll_rst,
    output logic       o_lock_lost,
    output logic [7:0] o_relock_cnt
);

    // state       | meaning
    // S_WAIT_LOCK | both resets held, counting consecutive lock_s cycles
    // S_PLL_RST   | retry build: pll_rst pulse, lock_s ignored
    // S_SYS_RUN   | system reset released, PSRAM power-up delay running
    // S_RUN       | both resets released
`ifdef PLL_RESEQ_RETRY_EN
    typedef enum logic [1:0] {S_WAIT_LOCK, S_PLL_RST, S_SYS_RUN, S_RUN} state_t;
`else
    typedef enum logic [1:0] {S_WAIT_LOCK, S_SYS_RUN, S_RUN} state_t;
`endif

    if (LOCK_STABLE < 1 || PSRAM_DELAY < 1 || LOCK_TIMEOUT < 1 || PLL_RST_CYC < 1 ||
        64'(LOCK_STABLE) >= (64'(1) << CNT_W) || 64'(PSRAM_DELAY) >= (64'(1) << CNT_W) ||
        64'(LOCK_TIMEOUT) >= (64'(1) << CNT_W)) begin : g_bad_params
        $error("pll_reset_sequencer: CNT_W too narrow or zero-length interval");
    end

    localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] PSRAM_TC  = CNT_W'(PSRAM_DELAY - 1);

    logic             r_lock_m;
    logic             r_lock_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sys_rst_n;
    logic             r_psram_rst_n;
    logic             r_lock_lost;
    logic [7:0]       r_relock_cnt;
    logic             w_lost;
    logic             w_stable_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lock_m <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_lock_m <= i_lock;
            r_lock_s <= r_lock_m;
        end
    end

    assign w_lost        = !r_lock_s && (r_state == S_SYS_RUN || r_state == S_RUN);
    assign w_stable_done = r_lock_s && (r_cnt == STABLE_TC);

`ifdef PLL_RESEQ_RETRY_EN
    localparam logic [CNT_W-1:0] TMO_TC = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] PLL_TC = CNT_W'(PLL_RST_CYC - 1);
    logic [CNT_W-1:0] r_tmo;
    logic             r_pll_rst;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_WAIT_LOCK;
            r_cnt         <= '0;
            r_sys_rst_n   <= 1'b0;
            r_psram_rst_n <= 1'b0;
            r_lock_lost   <= 1'b0;
            r_relock_cnt  <= '0;
`ifdef PLL_RESEQ_RETRY_EN
            r_tmo         <= '0;
            r_pll_rst     <= 1'b0;
`endif
        end else begin
            if (i_lock_lost_clr) begin
                r_lock_lost <= 1'b0;
            end
            if (w_lost) begin
                // set overrides the clear above
                r_state       <= S_WAIT_LOCK;
                r_cnt         <= '0;
                r_sys_rst_n   <= 1'b0;
                r_psram_rst_n <= 1'b0;
                r_lock_lost   <= 1'b1;
                if (r_relock_cnt != 8'hFF) begin
                    r_relock_cnt <= r_relock_cnt + 8'd1;
                end
            end else begin
                case (r_state)
                    S_WAIT_LOCK: begin
                        r_sys_rst_n   <= 1'b0;
                        r_psram_rst_n <= 1'b0;
                        if (!r_lock_s) begin
                            r_cnt <= '0;
                        end else if (w_stable_done) begin
                            r_cnt       <= '0;
                            r_sys_rst_n <= 1'b1;
                            r_state     <= S_SYS_RUN;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
`ifdef PLL_RESEQ_RETRY_EN
                        // stable completion takes priority over a simultaneous timeout
                        if (w_stable_done) begin
                            r_tmo <= '0;
                        end else if (r_tmo == TMO_TC) begin
                            r_tmo     <= '0;
                            r_cnt     <= '0;
                            r_pll_rst <= 1'b1;
                            r_state   <= S_PLL_RST;
                        end else begin
                            r_tmo <= r_tmo + CNT_W'(1);
                        end
`endif
                    end
`ifdef PLL_RESEQ_RETRY_EN
                    S_PLL_RST: begin
                        if (r_cnt == PLL_TC) begin
                            r_cnt     <= '0;
                            r_tmo     <= '0;
                            r_pll_rst <= 1'b0;
                            r_state   <= S_WAIT_LOCK;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
`endif
                    S_SYS_RUN: begin
                        if (r_cnt == PSRAM_TC) begin
                            r_cnt         <= '0;
                            r_psram_rst_n <= 1'b1;
                            r_state       <= S_RUN;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_RUN: begin
                        r_cnt <= '0;
                    end
                    default: begin
                        r_state <= S_WAIT_LOCK;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign o_sys_rst_n   = r_sys_rst_n;
    assign o_psram_rst_n = r_psram_rst_n;
    assign o_lock_lost   = r_lock_lost;
    assign o_relock_cnt  = r_relock_cnt;
`ifdef PLL_RESEQ_RETRY_EN
    assign o_pll_rst     = r_pll_rst;
`else
    assign o_pll_rst     = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with LOCK_STABLE=8, PSRAM_DELAY=16, LOCK_TIMEOUT=64, PLL_RST_CYC=4.
// Retry-only scenarios are compiled when PLL_RESEQ_RETRY_EN is defined.
module tb_pll_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lock = 1'b0;
    logic       lock_lost_clr = 1'b0;
    logic       sys_rst_n;
    logic       psram_rst_n;
    logic       pll_rst;
    logic       lock_lost;
    logic [7:0] relock_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .LOCK_STABLE (8),
        .PSRAM_DELAY (16),
        .LOCK_TIMEOUT(64),
        .PLL_RST_CYC (4),
        .CNT_W       (8)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_lock         (lock),
        .i_lock_lost_clr(lock_lost_clr),
        .o_sys_rst_n    (sys_rst_n),
        .o_psram_rst_n  (psram_rst_n),
        .o_pll_rst      (pll_rst),
        .o_lock_lost    (lock_lost),
        .o_relock_cnt   (relock_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 ns after an edge with rst_n released; the next edge is edge 1.
    task automatic do_reset(input logic lk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        lock = lk;
        lock_lost_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " sys"}, sys_rst_n, 0);
        chk({tag, " psram"}, psram_rst_n, 0);
        chk({tag, " pll"}, pll_rst, 0);
        chk({tag, " lost"}, lock_lost, 0);
        chk({tag, " relock"}, relock_cnt, 0);
    endtask

    // One loss event from WAIT_LOCK with lock_s low: 10 edges to SYS_RUN, 3 edges to detect loss.
    task automatic loss_event();
        lock = 1'b1;
        tick(10);
        lock = 1'b0;
        tick(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int pll_hi;

        // Reset values
        do_reset(1'b0);
        chk_reset_vals("rst");

        // 1: lock high from edge 1
        lock = 1'b1;
        pll_hi = 0;
        for (int k = 1; k <= 30; k++) begin
            tick(1);
            if (pll_rst) pll_hi++;
            if (k == 9)  chk("t1 sys@9", sys_rst_n, 0);
            if (k == 10) chk("t1 sys@10", sys_rst_n, 1);
            if (k == 25) chk("t1 psram@25", psram_rst_n, 0);
            if (k == 26) chk("t1 psram@26", psram_rst_n, 1);
        end
        chk("t1 pll never", pll_hi, 0);

        // 3: lock loss from RUN, relock, clear
        lock = 1'b0;
        tick(2);
        chk("t3 sys@2'", sys_rst_n, 1);
        tick(1);
        chk("t3 sys@3'", sys_rst_n, 0);
        chk("t3 psram@3'", psram_rst_n, 0);
        chk("t3 lost", lock_lost, 1);
        chk("t3 relock", relock_cnt, 1);
        lock = 1'b1;
        tick(9);
        chk("t3 resys@9", sys_rst_n, 0);
        tick(1);
        chk("t3 resys@10", sys_rst_n, 1);
        chk("t3 lost sticky", lock_lost, 1);
        lock_lost_clr = 1'b1;
        tick(1);
        lock_lost_clr = 1'b0;
        chk("t3 lost clr", lock_lost, 0);

        // 2: 1-cycle glitch in WAIT_LOCK restarts the stable count
        do_reset(1'b0);
        lock = 1'b1;
        tick(5);
        lock = 1'b0;
        tick(1);
        lock = 1'b1;
        for (int k = 7; k <= 16; k++) begin
            tick(1);
            if (k == 10) chk("t2 sys@10", sys_rst_n, 0);
            if (k == 15) chk("t2 sys@15", sys_rst_n, 0);
            if (k == 16) chk("t2 sys@16", sys_rst_n, 1);
        end
        chk("t2 relock", relock_cnt, 0);

        // 4: lock never arrives
        do_reset(1'b0);
`ifdef PLL_RESEQ_RETRY_EN
        begin
            int   rise1, rise2, fall1, nrise;
            logic prev, found;
            rise1 = -1; rise2 = -1; fall1 = -1; nrise = 0;
            prev = 1'b0;
            for (int k = 1; k <= 300; k++) begin
                tick(1);
                if (pll_rst && !prev) begin
                    nrise++;
                    if (nrise == 1) rise1 = k;
                    if (nrise == 2) rise2 = k;
                end
                if (!pll_rst && prev && fall1 < 0) fall1 = k;
                prev = pll_rst;
            end
            chk("t4 pulse width", fall1 - rise1, 4);
            chk("t4 pulse period", rise2 - rise1, 68);
            chk("t4 sys held", sys_rst_n, 0);
            found = 1'b0;
            for (int k = 0; k < 100 && !found; k++) begin
                tick(1);
                if (prev && !pll_rst) found = 1'b1;
                prev = pll_rst;
            end
            chk("t4 fall seen", found, 1);
            // lock arrives so that stable completes on the same edge as the timeout
            tick(54);
            lock = 1'b1;
            tick(9);
            chk("t4 tie sys@63", sys_rst_n, 0);
            tick(1);
            chk("t4 tie sys@64", sys_rst_n, 1);
            chk("t4 tie pll", pll_rst, 0);
            tick(16);
            chk("t4 tie psram", psram_rst_n, 1);
        end

        // 6a: reset during PLL_RST
        do_reset(1'b0);
        tick(65);
        chk("t6 in pll_rst", pll_rst, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("t6 plrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        lock = 1'b1;
        tick(10);
        chk("t6 plrst resys", sys_rst_n, 1);
`else
        pll_hi = 0;
        for (int k = 1; k <= 200; k++) begin
            tick(1);
            if (pll_rst) pll_hi++;
        end
        chk("t4 no pll", pll_hi, 0);
        chk("t4 sys held", sys_rst_n, 0);
`endif

        // 5: relock_cnt saturation and set-beats-clear
        do_reset(1'b0);
        for (int i = 1; i <= 300; i++) begin
            loss_event();
            if (i == 254) chk("t5 relock 254", relock_cnt, 254);
            if (i == 255) chk("t5 relock 255", relock_cnt, 255);
            if (i == 300) chk("t5 relock sat", relock_cnt, 255);
        end
        lock = 1'b1;
        tick(10);
        chk("t5 sysrun", sys_rst_n, 1);
        lock_lost_clr = 1'b1;
        tick(1);
        lock_lost_clr = 1'b0;
        chk("t5 lost clr", lock_lost, 0);
        lock = 1'b0;
        tick(2);
        lock_lost_clr = 1'b1;
        tick(1);
        lock_lost_clr = 1'b0;
        chk("t5 set wins", lock_lost, 1);
        chk("t5 loss sys", sys_rst_n, 0);
        chk("t5 relock held", relock_cnt, 255);

        // 6b: reset during SYS_RUN
        lock = 1'b1;
        tick(12);
        chk("t6 sysrun sys", sys_rst_n, 1);
        chk("t6 sysrun psram", psram_rst_n, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("t6 sysrun");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(9);
        chk("t6 again sys@9", sys_rst_n, 0);
        tick(1);
        chk("t6 again sys@10", sys_rst_n, 1);
        tick(16);
        chk("t6 again psram@26", psram_rst_n, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
